conv_stream_bridge: RTL

- Drives the image/handshake side of the binary 3x3 conv core and collects its result.
- Accepts a packed binary pixel stream over valid/ready and assembles IC channel bitmaps of IMG_IN_SIZE x IMG_IN_SIZE.
- Holds data_in_ready high for the core until the core pulses data_out_ready, then captures img_out.
- Streams the IMG_OUT_SIZE x IMG_OUT_SIZE result out over valid/ready. Sits between the input DMA/serial front end and one conv core.

---
 rtl/conv_pkg.sv | 30 +++
 rtl/result_serializer.sv | 59 +++++
 rtl/conv_stream_bridge.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the conv core stream bridge.
// Sizes are derived per instance from the module parameters through these functions.
package conv_pkg;

  typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

  localparam int DEF_IC          = 8;
  localparam int DEF_IMG_IN_SIZE = 30;
  localparam int DEF_W           = 8;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Pixels per bitmap of side sz.
  function automatic int pix_n(input int sz);
    return sz * sz;
  endfunction

  // Beats needed to move one bitmap of side sz at w pixels per beat.
  function automatic int beats(input int sz, input int w);
    return ceil_div(sz * sz, w);
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_serializer.sv
// Holds the captured core result and streams it out W pixels per beat, earliest pixel in bit 0.
// Latency: first beat valid the cycle after load; backpressure holds m_data/m_last stable while m_valid && !m_ready.
module result_serializer
  import conv_pkg::*;
#(
  parameter int M = 784,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [M-1:0] res_in,
  input  logic         m_ready,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  output logic         m_last,
  output logic         done
);

  localparam int BO  = ceil_div(M, W);
  localparam int K_W = ctr_w(BO);

  logic [BO*W-1:0] res_pad;
  logic [BO*W-1:0] res_q;
  logic [K_W-1:0]  beat;

  // Padding bits past M come out as zero on the final beat.
  assign res_pad = (BO*W)'(res_in);
  assign done    = m_valid && m_ready && m_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      beat    <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_data  <= res_pad[W-1:0];
      res_q   <= res_pad >> W;
      beat    <= '0;
      m_valid <= 1'b1;
      m_last  <= (BO == 1);
    end else if (m_valid && m_ready) begin
      if (m_last) begin
        m_valid <= 1'b0;
        m_data  <= '0;
        m_last  <= 1'b0;
        beat    <= '0;
      end else begin
        m_data <= res_q[W-1:0];
        res_q  <= res_q >> W;
        beat   <= beat + 1'b1;
        m_last <= (beat == K_W'(BO - 2));
      end
    end
  end

endmodule

// File: rtl/conv_stream_bridge.sv
// Loads IC binary bitmaps from a pixel stream, runs the conv core, then streams its result out.
// Optional CONV_STREAM_BRIDGE_TIMEOUT_EN adds a sticky err output and a RUN watchdog.
module conv_stream_bridge
  import conv_pkg::*;
#(
  parameter int IC           = DEF_IC,
  parameter int IMG_IN_SIZE  = DEF_IMG_IN_SIZE,
  parameter int IMG_OUT_SIZE = IMG_IN_SIZE - 2,
  parameter int W            = DEF_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [W-1:0]                         s_data,
  output logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]   img_in [0:IC-1],
  output logic                                 data_in_ready,
  input  logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] img_out,
  input  logic                                 data_out_ready,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [W-1:0]                         m_data,
  output logic                                 m_last
`ifdef CONV_STREAM_BRIDGE_TIMEOUT_EN
  ,
  output logic                                 err
`endif
);

  localparam int N     = pix_n(IMG_IN_SIZE);
  localparam int M     = pix_n(IMG_OUT_SIZE);
  localparam int BI    = beats(IMG_IN_SIZE, W);
  localparam int BI_W  = ctr_w(BI);
  localparam int CH_W  = ctr_w(IC);
  localparam int PIX_W = ctr_w(N);

  state_t          state;
  logic [BI_W-1:0] beat_cnt;
  logic [CH_W-1:0] ch_cnt;
  logic            cap;
  logic [M-1:0]    cap_dat;
  logic            done;
  logic            timeout_hit;

`ifdef CONV_STREAM_BRIDGE_TIMEOUT_EN
  localparam int L     = M * (IC + 1);
  localparam int TO    = 2 * L;
  localparam int RUN_W = ctr_w(TO);

  logic [RUN_W-1:0] run_cnt;

  // Fires on the edge that ends the TO-th RUN cycle; a real done pulse wins a tie.
  assign timeout_hit = (state == RUN) && !data_out_ready && (run_cnt == RUN_W'(TO - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign cap     = (state == RUN) && (data_out_ready || timeout_hit);
  assign cap_dat = data_out_ready ? img_out : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= LOAD;
      s_ready       <= 1'b0;
      data_in_ready <= 1'b0;
      beat_cnt      <= '0;
      ch_cnt        <= '0;
      img_in        <= '{default: '0};
    end else begin
      case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            // Bits landing past the end of the bitmap are dropped.
            for (int i = 0; i < W; i++) begin
              if (int'(beat_cnt) * W + i < N)
                img_in[ch_cnt][PIX_W'(int'(beat_cnt) * W + i)] <= s_data[i];
            end
            if (beat_cnt == BI_W'(BI - 1)) begin
              beat_cnt <= '0;
              if (ch_cnt == CH_W'(IC - 1)) begin
                ch_cnt        <= '0;
                state         <= RUN;
                s_ready       <= 1'b0;
                data_in_ready <= 1'b1;
              end else begin
                ch_cnt <= ch_cnt + 1'b1;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RUN: begin
          // Dropping data_in_ready right after the pulse keeps the core from restarting.
          if (cap) begin
            data_in_ready <= 1'b0;
            state         <= DRAIN;
          end
        end
        DRAIN: begin
          if (done) begin
            state   <= LOAD;
            s_ready <= 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef CONV_STREAM_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt <= '0;
      err     <= 1'b0;
    end else if (state == RUN && !cap) begin
      run_cnt <= run_cnt + 1'b1;
    end else begin
      run_cnt <= '0;
      if (timeout_hit) err <= 1'b1;
    end
  end
`endif

  result_serializer #(
    .M (M),
    .W (W)
  ) u_result_serializer (
    .clk     (clk),
    .rst     (rst),
    .load    (cap),
    .res_in  (cap_dat),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_last  (m_last),
    .done    (done)
  );

endmodule
